// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-queue definitions.
// Holds the widths that other blocks in the front end also use: the program
// counter width, the instruction width and the default fetch-queue depth.
// It also holds the classification of an incoming memory response and a
// helper that sizes occupancy counters.
package if_fetch_queue_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INST_WIDTH  = 32;
    localparam int FETCH_DEPTH = 4;

    // What a response does to the queue in a cycle without flush.
    typedef enum logic [1:0] {
        RSP_NONE   = 2'd0,  // no response this cycle
        RSP_KEEP   = 2'd1,  // matches a live request, goes to the buffer
        RSP_DROP   = 2'd2,  // belongs to a request killed by an earlier flush
        RSP_ORPHAN = 2'd3   // nothing outstanding: protocol error, ignored
    } rsp_kind_e;

    // Number of bits needed to hold a count from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// sync_fifo: single-clock circular FIFO with a synchronous clear.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   clear_i          empties the FIFO (wins over push and pop)
//   push_i/push_data_i  write one entry at the tail
//   pop_i            drop the head entry
//   head_data_o      head entry (valid while count_o != 0)
//   count_o          number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// A push into a full FIFO is only taken when a pop happens in the same cycle;
// a pop from an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    import if_fetch_queue_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push and pop against the current fill level.
    always_comb begin
        full_s    = (count_q == CNT_W'(DEPTH));
        empty_s   = (count_q == {CNT_W{1'b0}});
        pop_ok_s  = pop_i && !empty_s;
        push_ok_s = push_i && (!full_s || pop_ok_s);
    end

    // Next pointers and count; clear empties the FIFO regardless of traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear_i && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch front end between the PC generator,
// the instruction memory and decode.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc_in                         fetch PC from the PC generator
//   flush                         redirect; kills every fetch in flight
//   fetch_stall                   PC generator must hold pc_in this cycle
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_rsp_valid/data           in-order response channel, no backpressure
//   id_valid/ready, id_pc/inst    instruction presented to decode
// Requests are only issued while the sum of live requests, requests whose
// responses must be discarded and buffered instructions is below DEPTH, so a
// response always finds room in the buffer. Requests killed by a flush keep
// occupying a slot until their response comes back and is dropped.
module if_fetch_queue #(
    parameter int DEPTH      = if_fetch_queue_pkg::FETCH_DEPTH,
    parameter int INST_WIDTH = if_fetch_queue_pkg::INST_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [if_fetch_queue_pkg::PC_WIDTH-1:0] pc_in,
    input  logic                                flush,
    output logic                                fetch_stall,
    output logic                                imem_req_valid,
    input  logic                                imem_req_ready,
    output logic [if_fetch_queue_pkg::PC_WIDTH-1:0] imem_req_addr,
    input  logic                                imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]               imem_rsp_data,
    output logic                                id_valid,
    input  logic                                id_ready,
    output logic [if_fetch_queue_pkg::PC_WIDTH-1:0] id_pc,
    output logic [INST_WIDTH-1:0]               id_inst
);
    import if_fetch_queue_pkg::*;

    localparam int CNT_W = count_width(DEPTH);
    localparam int SUM_W = CNT_W + 2;
    localparam int BUF_W = PC_WIDTH + INST_WIDTH;

    // Tag queue occupancy is exactly the number of live requests.
    logic [CNT_W-1:0]    live_s;
    logic [CNT_W-1:0]    occ_s;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [CNT_W:0]      flush_total_s;
    logic [SUM_W-1:0]    inflight_sum_s;
    logic [PC_WIDTH-1:0] tag_head_s;
    logic [BUF_W-1:0]    buf_head_s;
    logic [BUF_W-1:0]    buf_push_data_s;
    rsp_kind_e           rsp_kind_s;
    logic                req_valid_s;
    logic                req_fire_s;
    logic                id_valid_s;
    logic                fifo_clear_s;
    logic                tag_push_s;
    logic                tag_pop_s;
    logic                buf_push_s;
    logic                buf_pop_s;

    // Request gating: all slots, including those of dropped requests, count.
    always_comb begin
        inflight_sum_s = SUM_W'(live_s) + SUM_W'(drop_q) + SUM_W'(occ_s);
        req_valid_s    = !rst && !flush && (inflight_sum_s < SUM_W'(DEPTH));
        req_fire_s     = req_valid_s && imem_req_ready;
        id_valid_s     = (occ_s != {CNT_W{1'b0}});
    end

    // Classify the response; killed requests are always answered first.
    always_comb begin
        rsp_kind_s = RSP_NONE;
        if (!imem_rsp_valid) begin
            rsp_kind_s = RSP_NONE;
        end else if (drop_q != {CNT_W{1'b0}}) begin
            rsp_kind_s = RSP_DROP;
        end else if (live_s != {CNT_W{1'b0}}) begin
            rsp_kind_s = RSP_KEEP;
        end else begin
            rsp_kind_s = RSP_ORPHAN;
        end
    end

    // Queue control and drop-count update; flush wins over every other event.
    always_comb begin
        fifo_clear_s  = 1'b0;
        tag_push_s    = 1'b0;
        tag_pop_s     = 1'b0;
        buf_push_s    = 1'b0;
        buf_pop_s     = 1'b0;
        drop_d        = drop_q;
        flush_total_s = {1'b0, live_s} + {1'b0, drop_q};
        if (flush) begin
            fifo_clear_s = 1'b1;
            // A response arriving with the flush retires one killed request.
            if (imem_rsp_valid && (flush_total_s != {(CNT_W+1){1'b0}})) begin
                drop_d = CNT_W'(flush_total_s - {{CNT_W{1'b0}}, 1'b1});
            end else begin
                drop_d = CNT_W'(flush_total_s);
            end
        end else begin
            tag_push_s = req_fire_s;
            buf_pop_s  = id_valid_s && id_ready;
            case (rsp_kind_s)
                RSP_DROP: drop_d = drop_q - CNT_W'(1'b1);
                RSP_KEEP: begin
                    tag_pop_s  = 1'b1;
                    buf_push_s = 1'b1;
                end
                default:  drop_d = drop_q;
            endcase
        end
    end

    // Count of responses still to be discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= {CNT_W{1'b0}};
        end else begin
            drop_q <= drop_d;
        end
    end

    assign buf_push_data_s = {tag_head_s, imem_rsp_data};

    sync_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_queue (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (fifo_clear_s),
        .push_i      (tag_push_s),
        .push_data_i (pc_in),
        .pop_i       (tag_pop_s),
        .head_data_o (tag_head_s),
        .count_o     (live_s)
    );

    sync_fifo #(
        .WIDTH (BUF_W),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (fifo_clear_s),
        .push_i      (buf_push_s),
        .push_data_i (buf_push_data_s),
        .pop_i       (buf_pop_s),
        .head_data_o (buf_head_s),
        .count_o     (occ_s)
    );

    // Decode sees only registered buffer state; the head is masked to zero
    // when empty so stale storage never leaks out.
    always_comb begin
        if (id_valid_s) begin
            id_pc   = buf_head_s[BUF_W-1:INST_WIDTH];
            id_inst = buf_head_s[INST_WIDTH-1:0];
        end else begin
            id_pc   = {PC_WIDTH{1'b0}};
            id_inst = {INST_WIDTH{1'b0}};
        end
    end

    assign id_valid       = id_valid_s;
    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_in;
    assign fetch_stall    = !req_fire_s;

endmodule
